// File: rtl/bram_delay_prog.sv
// Runtime-programmable BRAM delay line: dout is din delayed by delay_cur ce-qualified samples,
// with a fill-tracking valid flag, zeroed output while priming, and range-checked reloads.
module bram_delay_prog #(
    parameter int    WIDTH         = 128,
    parameter int    MAX_DELAY     = 1024,
    parameter int    DEFAULT_DELAY = 128,
    parameter int    LATENCY       = 2,
    parameter string TARGET_DEVICE = "VIRTEX5"
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ce,
    input  logic [WIDTH-1:0]                   din,
    input  logic [$clog2(MAX_DELAY+1)-1:0]     delay_in,
    input  logic                               delay_ld,
    output logic [WIDTH-1:0]                   dout,
    output logic                               dout_valid,
    output logic [$clog2(MAX_DELAY+1)-1:0]     delay_cur,
    output logic                               cfg_err
);

    localparam int DW    = $clog2(MAX_DELAY + 1);
    localparam int AW    = $clog2(MAX_DELAY);
    localparam int DEPTH = 1 << AW;

    // Widest legal simple-dual-port width for one primitive at this depth.
    function automatic int tile_width(input int depth, input bit big);
        int w;
        w = (big ? 36864 : 18432) / depth;
        if (big && w >= 72) return 72;
        if (w >= 36) return 36;
        if (w >= 18) return 18;
        if (w >= 9)  return 9;
        if (w >= 4)  return 4;
        if (w >= 2)  return 2;
        return 1;
    endfunction

    localparam bit BIG_TILE = (TARGET_DEVICE == "VIRTEX6");
    localparam int TILE_W   = tile_width(DEPTH, BIG_TILE);
    localparam int N_TILES  = (WIDTH + TILE_W - 1) / TILE_W;
    localparam int PAD_W    = N_TILES * TILE_W;

    logic [PAD_W-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        fill;
    logic [DW-1:0]        fill_nxt;
    logic                 ld_ok;
    logic                 primed_nxt;
    logic [PAD_W-1:0]     rd_word;
    logic [WIDTH-1:0]     rd_data;
    logic [PAD_W-WIDTH:0] rd_pad_unused;

    assign ld_ok      = (delay_in >= DW'(LATENCY + 1)) && (delay_in <= DW'(MAX_DELAY));
    assign fill_nxt   = (fill == delay_cur) ? fill : fill + 1'b1;
    assign primed_nxt = (fill_nxt == delay_cur);

    // The slot read here lands on dout exactly when it is delay_cur-1 writes old.
    assign rd_addr = wr_ptr - AW'(delay_cur - DW'(LATENCY));

    assign {rd_pad_unused, rd_data} = {1'b0, rd_word};

    // NOTE: storage and its read register have no reset; BRAM cannot clear its array,
    // and stale contents never reach dout because dout_valid masks them.
    always_ff @(posedge clk) begin
        if (ce) begin
            mem[wr_ptr] <= PAD_W'(din);
        end
    end

    generate
        if (LATENCY == 2) begin : g_out_reg
            always_ff @(posedge clk) begin
                if (delay_ld && ld_ok) begin
                    rd_word <= '0;
                end else if (ce) begin
                    rd_word <= mem[rd_addr];
                end
            end
        end else begin : g_direct
            assign rd_word = mem[rd_addr];
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            fill       <= '0;
            delay_cur  <= DW'(DEFAULT_DELAY);
            dout       <= '0;
            dout_valid <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= delay_ld && !ld_ok;
            if (ce) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (delay_ld && ld_ok) begin
                // A sample written in the load cycle is the first one of the new fill.
                delay_cur  <= delay_in;
                fill       <= DW'(ce);
                dout       <= '0;
                dout_valid <= 1'b0;
            end else if (ce) begin
                fill       <= fill_nxt;
                dout_valid <= primed_nxt;
                dout       <= primed_nxt ? rd_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_bram_delay_prog.sv
// Directed self-checking bench for bram_delay_prog; a sample-queue model supplies expected outputs.
module tb_bram_delay_prog;

    localparam int WIDTH         = 128;
    localparam int MAX_DELAY     = 1024;
    localparam int DEFAULT_DELAY = 128;
    localparam int LATENCY       = 2;
    localparam int DW            = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ce = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [DW-1:0]    delay_in = '0;
    logic             delay_ld = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [DW-1:0]    delay_cur;
    logic             cfg_err;

    always #5 clk = ~clk;

    bram_delay_prog #(
        .WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .DEFAULT_DELAY(DEFAULT_DELAY),
        .LATENCY(LATENCY), .TARGET_DEVICE("VIRTEX5")
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .delay_in(delay_in),
        .delay_ld(delay_ld), .dout(dout), .dout_valid(dout_valid),
        .delay_cur(delay_cur), .cfg_err(cfg_err)
    );

    // Model: the last m_d samples of the current fill, oldest first.
    logic [WIDTH-1:0] q[$];
    int               m_d = DEFAULT_DELAY;
    logic             exp_valid = 1'b0;
    logic [WIDTH-1:0] exp_dout = '0;
    logic             exp_err = 1'b0;
    int               seq = 0;
    int               n_tests = 0;
    int               n_fail = 0;

    function automatic logic [WIDTH-1:0] sample(input int s);
        return {s[31:0], 64'h0123_4567_89AB_CDEF, ~s[31:0]};
    endfunction

    task automatic model_reset();
        q.delete();
        m_d       = DEFAULT_DELAY;
        exp_valid = 1'b0;
        exp_dout  = '0;
        exp_err   = 1'b0;
    endtask

    // One clock: apply inputs, advance the model on the edge, return 1 time unit later.
    task automatic drive(input logic c, input logic ld, input int dv);
        logic [WIDTH-1:0] d;
        d        = sample(seq + 1);
        ce       = c;
        din      = d;
        delay_ld = ld;
        delay_in = DW'(dv);
        @(posedge clk);
        if (c) seq++;
        exp_err = ld && (dv < LATENCY + 1 || dv > MAX_DELAY);
        if (ld && !exp_err) begin
            m_d = dv;
            q.delete();
            if (c) q.push_back(d);
            exp_valid = 1'b0;
            exp_dout  = '0;
        end else if (c) begin
            q.push_back(d);
            if (q.size() > m_d) q.delete(0);
            exp_valid = (q.size() == m_d);
            exp_dout  = exp_valid ? q[0] : '0;
        end
        #1;
        ce       = 1'b0;
        delay_ld = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (dout !== '0 || dout_valid !== 1'b0 || cfg_err !== 1'b0 || delay_cur !== DW'(DEFAULT_DELAY)) begin
            n_fail++;
            $display("FAIL reset: dout=%h valid=%b err=%b dcur=%0d, expected 0/0/0/%0d",
                     dout, dout_valid, cfg_err, delay_cur, DEFAULT_DELAY);
        end
    endtask

    task automatic test_default_stream();
        for (int i = 1; i <= 140; i++) begin
            drive(1'b1, 1'b0, 0);
            n_tests++;
            if (dout !== exp_dout || dout_valid !== exp_valid || cfg_err !== exp_err || delay_cur !== DW'(m_d)) begin
                n_fail++;
                $display("FAIL default_stream ce#%0d: dout=%h valid=%b err=%b dcur=%0d, expected %h/%b/%b/%0d",
                         i, dout, dout_valid, cfg_err, delay_cur, exp_dout, exp_valid, exp_err, m_d);
            end
            if (i == 127 || i == 128) begin
                n_tests++;
                if (dout_valid !== (i == 128) || dout !== ((i == 128) ? sample(1) : '0)) begin
                    n_fail++;
                    $display("FAIL default_edge ce#%0d: valid=%b dout=%h", i, dout_valid, dout);
                end
            end
        end
    endtask

    task automatic test_gated_ce();
        logic [63:0] pat;
        pat = 64'hB4E1_9D36_A7C2_5F08;
        drive(1'b0, 1'b1, 5);
        for (int i = 0; i < 64; i++) begin
            drive(pat[i], 1'b0, 0);
            n_tests++;
            if (dout !== exp_dout || dout_valid !== exp_valid || cfg_err !== exp_err || delay_cur !== DW'(m_d)) begin
                n_fail++;
                $display("FAIL gated_ce step%0d ce=%b: dout=%h valid=%b err=%b dcur=%0d, expected %h/%b/%b/%0d",
                         i, pat[i], dout, dout_valid, cfg_err, delay_cur, exp_dout, exp_valid, exp_err, m_d);
            end
        end
    endtask

    task automatic test_reload();
        // Prime at 128, then shrink to the minimum delay while streaming.
        drive(1'b1, 1'b1, 128);
        for (int i = 0; i < 130; i++) drive(1'b1, 1'b0, 0);
        n_tests++;
        if (dout_valid !== 1'b1 || dout !== exp_dout) begin
            n_fail++;
            $display("FAIL reload_primed: valid=%b dout=%h, expected 1/%h", dout_valid, dout, exp_dout);
        end
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, i == 1, 3);
            n_tests++;
            if (dout !== exp_dout || dout_valid !== (i >= 3) || delay_cur !== DW'(3)) begin
                n_fail++;
                $display("FAIL reload_min ce#%0d: dout=%h valid=%b dcur=%0d, expected %h/%b/3",
                         i, dout, dout_valid, delay_cur, exp_dout, i >= 3);
            end
        end
    endtask

    task automatic test_bad_cfg();
        int bad[2];
        bad[0] = 2;
        bad[1] = MAX_DELAY + 1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, bad[k]);
            n_tests++;
            if (cfg_err !== 1'b1 || delay_cur !== DW'(3) || dout_valid !== 1'b1 || dout !== exp_dout) begin
                n_fail++;
                $display("FAIL bad_cfg_pulse d=%0d: err=%b dcur=%0d valid=%b, expected 1/3/1",
                         bad[k], cfg_err, delay_cur, dout_valid);
            end
            drive(1'b0, 1'b0, 0);
            n_tests++;
            if (cfg_err !== 1'b0 || delay_cur !== DW'(3) || dout_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_cfg_clear d=%0d: err=%b dcur=%0d valid=%b, expected 0/3/1",
                         bad[k], cfg_err, delay_cur, dout_valid);
            end
        end
    endtask

    task automatic test_restart();
        // Same-value reload, idle load (no ce), and reload while still priming.
        int steps[10][3] = '{'{1, 1, 3}, '{1, 0, 0}, '{1, 0, 0}, '{1, 0, 0}, '{0, 1, 4},
                             '{1, 0, 0}, '{1, 0, 0}, '{1, 1, 4}, '{1, 0, 0}, '{1, 0, 0}};
        for (int i = 0; i < 14; i++) begin
            if (i < 10) drive(steps[i][0] != 0, steps[i][1] != 0, steps[i][2]);
            else        drive(1'b1, 1'b0, 0);
            n_tests++;
            if (dout !== exp_dout || dout_valid !== exp_valid || cfg_err !== exp_err || delay_cur !== DW'(m_d)) begin
                n_fail++;
                $display("FAIL restart step%0d: dout=%h valid=%b err=%b dcur=%0d, expected %h/%b/%b/%0d",
                         i, dout, dout_valid, cfg_err, delay_cur, exp_dout, exp_valid, exp_err, m_d);
            end
        end
    endtask

    task automatic test_max_wrap();
        drive(1'b1, 1'b1, MAX_DELAY);
        for (int i = 2; i <= 3000; i++) begin
            drive(1'b1, 1'b0, 0);
            n_tests++;
            if (dout !== exp_dout || dout_valid !== exp_valid || delay_cur !== DW'(MAX_DELAY)) begin
                n_fail++;
                $display("FAIL max_wrap ce#%0d: dout=%h valid=%b dcur=%0d, expected %h/%b/%0d",
                         i, dout, dout_valid, delay_cur, exp_dout, exp_valid, MAX_DELAY);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (dout !== '0 || dout_valid !== 1'b0 || delay_cur !== DW'(DEFAULT_DELAY) || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: dout=%h valid=%b dcur=%0d err=%b, expected 0/0/%0d/0",
                     dout, dout_valid, delay_cur, cfg_err, DEFAULT_DELAY);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 132; i++) begin
            drive(1'b1, 1'b0, 0);
            n_tests++;
            if (dout !== exp_dout || dout_valid !== exp_valid || cfg_err !== exp_err || delay_cur !== DW'(m_d)) begin
                n_fail++;
                $display("FAIL reset_refill ce#%0d: dout=%h valid=%b err=%b dcur=%0d, expected %h/%b/%b/%0d",
                         i, dout, dout_valid, cfg_err, delay_cur, exp_dout, exp_valid, exp_err, m_d);
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_default_stream();
        test_gated_ce();
        test_reload();
        test_bad_cfg();
        test_restart();
        test_max_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
